// File: rtl/dct_block_buffer_pkg.sv
// Shared definitions for the 8x8 DCT sample buffer and the blocks that address it.
// Read addresses are packed {u,v}, so sample k = u*8+v sits at address k.
package dct_block_buffer_pkg;

  typedef enum logic [1:0] {
    VAZIO      = 2'b00,
    CARREGANDO = 2'b01,
    PRONTO     = 2'b10
  } buf_state_t;

  localparam int BLOCK_DIM  = 8;
  localparam int BLOCK_SIZE = BLOCK_DIM * BLOCK_DIM;

  function automatic logic [5:0] pack_addr(input logic [2:0] u, input logic [2:0] v);
    return {u, v};
  endfunction

endpackage

// File: rtl/dct_block_buffer_if.sv
// Load and read handshake between the sample source/controller (master) and the buffer (slave).
interface dct_block_buffer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic              Load_Start;
  logic [DATA_W-1:0] Sample_In;
  logic              Sample_Valid;
  logic              Load_Done;
  logic              Busy;
  logic              Read_Enable;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] Data_Out;
  logic              Data_Valid;
  logic              Read_Error;

  modport master (
    output Load_Start, Sample_In, Sample_Valid, Read_Enable, Address,
    input  Load_Done, Busy, Data_Out, Data_Valid, Read_Error
  );

  modport slave (
    input  Load_Start, Sample_In, Sample_Valid, Read_Enable, Address,
    output Load_Done, Busy, Data_Out, Data_Valid, Read_Error
  );
endinterface

// File: rtl/dct_sample_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// Only the read register is reset; the array keeps its contents.
module dct_sample_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Holds the last word between reads so the MAC operand stays stable.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/dct_block_buffer.sv
// 8x8 block buffer: serial 64-sample load, then 1-cycle-latency reads for the DCT controller.
module dct_block_buffer
  import dct_block_buffer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic             Clock,
  input  logic             Reset,
  dct_block_buffer_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(BLOCK_SIZE - 1);

  buf_state_t        state, next_state;
  logic [ADDR_W-1:0] ptr;
  logic              write_en, last_write, read_ok, busy;
  logic              load_done, data_valid, read_error;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= VAZIO;
    else       state <= next_state;
  end

  // Reads are legal only in PRONTO; Load_Start while loading does not restart.
  always_comb begin
    next_state = state;
    write_en   = 1'b0;
    last_write = 1'b0;
    read_ok    = 1'b0;
    busy       = 1'b0;
    case (state)
      VAZIO: begin
        if (bus.Load_Start) next_state = CARREGANDO;
      end
      CARREGANDO: begin
        busy     = 1'b1;
        write_en = bus.Sample_Valid;
        if (bus.Sample_Valid && ptr == LAST_PTR) begin
          last_write = 1'b1;
          next_state = PRONTO;
        end
      end
      PRONTO: begin
        read_ok = bus.Read_Enable;
        if (bus.Load_Start) next_state = CARREGANDO;
      end
      default: next_state = VAZIO;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ptr <= '0;
    end else if (write_en) begin
      ptr <= ptr + 1'b1;
    end else if (state == PRONTO && bus.Load_Start) begin
      ptr <= '0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      load_done  <= 1'b0;
      data_valid <= 1'b0;
      read_error <= 1'b0;
    end else begin
      load_done  <= last_write;
      data_valid <= read_ok;
      read_error <= bus.Read_Enable && !read_ok;
    end
  end

  dct_sample_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .Clock   (Clock),
    .Reset   (Reset),
    .wr_en   (write_en),
    .wr_addr (ptr),
    .wr_data (bus.Sample_In),
    .rd_en   (read_ok),
    .rd_addr (bus.Address),
    .rd_data (bus.Data_Out)
  );

  assign bus.Busy       = busy;
  assign bus.Load_Done  = load_done;
  assign bus.Data_Valid = data_valid;
  assign bus.Read_Error = read_error;

endmodule
